// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// cpu_control_fsm -- multicycle MIPS-subset control unit (FETCH/EXEC1/EXEC2)
// with sticky illegal-instruction and bus-timeout faults.        Rev 1.0
// ============================================================================
module cpu_control_fsm #(
   parameter int WAIT_LIMIT = 16,
   parameter int WAIT_W     = 8,
   parameter int RET_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [5:0]       opcode_i,
   input  logic [5:0]       function_i,
   input  logic             waitrequest_i,
   input  logic             jr_zero_i,
   output logic             pc_wen_o,
   output logic             ir_wen_o,
   output logic             ram_wen_o,
   output logic             ram_rds_o,
   output logic             reg_wen_o,
   output logic             src_b_sel_o,
   output logic             ram_a_sel_o,
   output logic             reg_wd_sel_o,
   output logic             reg_a3_sel_o,
   output logic [2:0]       alu_op_o,
   output logic [2:0]       state_o,
   output logic             active_o,
   output logic             illegal_o,
   output logic             timeout_o,
   output logic [RET_W-1:0] retired_o
);

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC1 = 3'd1,
      ST_EXEC2 = 3'd2,
      ST_HALT  = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;
   localparam logic [2:0] ALU_LUI = 3'd5;

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAIT_LIMIT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [RET_W-1:0]  retired_q, retired_d;
   logic              illegal_q, illegal_d;
   logic              timeout_q, timeout_d;

   logic              is_lw, is_sw, is_mem, is_jr, is_r_alu, is_i_alu, is_legal, use_imm;
   logic [2:0]        dec_alu_op;
   logic [WAIT_W-1:0] wait_inc;
   logic              wait_hit;

   always_comb begin
      is_lw      = (opcode_i == OP_LW);
      is_sw      = (opcode_i == OP_SW);
      is_jr      = 1'b0;
      is_r_alu   = 1'b0;
      is_i_alu   = 1'b0;
      dec_alu_op = ALU_ADD;
      if (opcode_i == OP_SPECIAL) begin
         case (function_i)
            FN_JR:   is_jr = 1'b1;
            FN_ADDU: begin is_r_alu = 1'b1; dec_alu_op = ALU_ADD; end
            FN_SUBU: begin is_r_alu = 1'b1; dec_alu_op = ALU_SUB; end
            FN_AND:  begin is_r_alu = 1'b1; dec_alu_op = ALU_AND; end
            FN_OR:   begin is_r_alu = 1'b1; dec_alu_op = ALU_OR;  end
            FN_XOR:  begin is_r_alu = 1'b1; dec_alu_op = ALU_XOR; end
            default: ;
         endcase
      end else begin
         case (opcode_i)
            OP_ADDIU: begin is_i_alu = 1'b1; dec_alu_op = ALU_ADD; end
            OP_ANDI:  begin is_i_alu = 1'b1; dec_alu_op = ALU_AND; end
            OP_ORI:   begin is_i_alu = 1'b1; dec_alu_op = ALU_OR;  end
            OP_XORI:  begin is_i_alu = 1'b1; dec_alu_op = ALU_XOR; end
            OP_LUI:   begin is_i_alu = 1'b1; dec_alu_op = ALU_LUI; end
            default: ;
         endcase
      end
      is_mem   = is_lw | is_sw;
      use_imm  = is_i_alu | is_mem;
      is_legal = is_mem | is_jr | is_r_alu | is_i_alu;
   end

   // A wait cycle that would bring the counter to the limit is the timeout cycle itself.
   assign wait_inc = wait_cnt_q + WAIT_W'(1);
   assign wait_hit = waitrequest_i && (wait_inc == WAIT_MAX);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = '0;
      retired_d    = retired_q;
      illegal_d    = illegal_q;
      timeout_d    = timeout_q;
      pc_wen_o     = 1'b0;
      ir_wen_o     = 1'b0;
      ram_wen_o    = 1'b0;
      ram_rds_o    = 1'b0;
      reg_wen_o    = 1'b0;
      src_b_sel_o  = 1'b0;
      ram_a_sel_o  = 1'b0;
      reg_wd_sel_o = 1'b0;
      reg_a3_sel_o = 1'b0;
      alu_op_o     = ALU_ADD;
      case (state_q)
         ST_FETCH: begin
            if (wait_hit) begin
               state_d   = ST_FAULT;
               timeout_d = 1'b1;
            end else begin
               ram_rds_o = 1'b1;
               if (waitrequest_i) wait_cnt_d = wait_inc;
               else               state_d    = ST_EXEC1;
            end
         end
         ST_EXEC1: begin
            if (!is_legal) begin
               state_d   = ST_FAULT;
               illegal_d = 1'b1;
            end else if (is_mem && wait_hit) begin
               state_d   = ST_FAULT;
               timeout_d = 1'b1;
            end else begin
               alu_op_o     = dec_alu_op;
               src_b_sel_o  = use_imm;
               reg_wd_sel_o = !is_lw;
               reg_a3_sel_o = is_r_alu;
               ram_a_sel_o  = is_mem;
               ram_rds_o    = is_lw;
               ram_wen_o    = is_sw;
               if (is_mem && waitrequest_i) begin
                  wait_cnt_d = wait_inc;
               end else begin
                  ir_wen_o = 1'b1;
                  state_d  = ST_EXEC2;
               end
            end
         end
         ST_EXEC2: begin
            alu_op_o     = dec_alu_op;
            src_b_sel_o  = use_imm;
            reg_wd_sel_o = !is_lw;
            reg_a3_sel_o = is_r_alu;
            pc_wen_o     = 1'b1;
            reg_wen_o    = is_lw | is_r_alu | is_i_alu;
            retired_d    = retired_q + RET_W'(1);
            state_d      = (is_jr && jr_zero_i) ? ST_HALT : ST_FETCH;
         end
         ST_HALT, ST_FAULT: ;
         default: state_d = ST_FAULT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_FETCH;
         wait_cnt_q <= '0;
         retired_q  <= '0;
         illegal_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         retired_q  <= retired_d;
         illegal_q  <= illegal_d;
         timeout_q  <= timeout_d;
      end
   end

   assign state_o   = state_q;
   assign active_o  = (state_q != ST_HALT) && (state_q != ST_FAULT);
   assign illegal_o = illegal_q;
   assign timeout_o = timeout_q;
   assign retired_o = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_fsm -- directed scoreboard bench for cpu_control_fsm.  Rev 1.0
// ============================================================================
module tb_cpu_control_fsm;

   localparam int AX = -1;
   // Strobe vector order: {pc, ir, ram_wen, ram_rds, reg_wen, src_b, ram_a, wd_sel, a3_sel}
   localparam logic [8:0] PC  = 9'h100;
   localparam logic [8:0] IR  = 9'h080;
   localparam logic [8:0] RW  = 9'h040;
   localparam logic [8:0] RR  = 9'h020;
   localparam logic [8:0] GW  = 9'h010;
   localparam logic [8:0] SB  = 9'h008;
   localparam logic [8:0] RA  = 9'h004;
   localparam logic [8:0] WD  = 9'h002;
   localparam logic [8:0] A3  = 9'h001;
   localparam logic [8:0] SEL = 9'h00F;
   localparam logic [8:0] NO  = 9'h000;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_SW      = 6'h2B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_BAD     = 6'h3F;
   localparam logic [5:0] FN_NONE    = 6'h00;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUBU    = 6'h23;

   typedef struct packed {
      logic [20:0] val;
      logic [20:0] care;
   } exp_t;

   typedef struct {
      string tag;
      exp_t  e;
   } sb_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       waitrequest;
   logic       jr_zero;
   logic       pc_wen, ir_wen, ram_wen, ram_rds, reg_wen;
   logic       src_b_sel, ram_a_sel, reg_wd_sel, reg_a3_sel;
   logic [2:0] alu_op;
   logic [2:0] state;
   logic       active, illegal, timeout;
   logic [2:0] retired;

   sb_t         sb_q[$];
   int          n_assert = 0;
   int          n_fail = 0;
   logic [20:0] obs;

   cpu_control_fsm #(
      .WAIT_LIMIT(4),
      .WAIT_W    (8),
      .RET_W     (3)
   ) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .opcode_i     (opcode),
      .function_i   (funct),
      .waitrequest_i(waitrequest),
      .jr_zero_i    (jr_zero),
      .pc_wen_o     (pc_wen),
      .ir_wen_o     (ir_wen),
      .ram_wen_o    (ram_wen),
      .ram_rds_o    (ram_rds),
      .reg_wen_o    (reg_wen),
      .src_b_sel_o  (src_b_sel),
      .ram_a_sel_o  (ram_a_sel),
      .reg_wd_sel_o (reg_wd_sel),
      .reg_a3_sel_o (reg_a3_sel),
      .alu_op_o     (alu_op),
      .state_o      (state),
      .active_o     (active),
      .illegal_o    (illegal),
      .timeout_o    (timeout),
      .retired_o    (retired)
   );

   always #5 clk = ~clk;

   assign obs = {state, pc_wen, ir_wen, ram_wen, ram_rds, reg_wen, src_b_sel, ram_a_sel,
                 reg_wd_sel, reg_a3_sel, alu_op, active, illegal, timeout, retired};

   // Bits set in dc are not checked; alu = AX leaves alu_op unchecked.
   function automatic exp_t ev(input logic [2:0] st, input logic [8:0] stb, input logic [8:0] dc,
                               input int alu, input logic [2:0] ret, input logic ill, input logic tmo);
      exp_t e;
      logic act;
      act    = (st != 3'd3) && (st != 3'd4);
      e.val  = {st, stb & ~dc, (alu < 0) ? 3'd0 : 3'(alu), act, ill, tmo, ret};
      e.care = {3'b111, ~dc, (alu < 0) ? 3'b000 : 3'b111, 6'b111111};
      return e;
   endfunction

   task automatic check_head();
      sb_t r;
      r = sb_q.pop_front();
      n_assert++;
      assert ((obs & r.e.care) === (r.e.val & r.e.care))
         else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b (care mask %b)", r.tag, obs, r.e.val, r.e.care);
         end
   endtask

   task automatic expect_now(input string tag, input exp_t e);
      sb_q.push_back('{tag, e});
      check_head();
   endtask

   task automatic step(input string tag, input logic wr, input logic [5:0] op,
                       input logic [5:0] fn, input logic jz, input exp_t e);
      waitrequest = wr;
      opcode      = op;
      funct       = fn;
      jr_zero     = jz;
      sb_q.push_back('{tag, e});
      @(negedge clk);
      check_head();
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                            input logic jz, input logic [2:0] ret,
                            input logic [8:0] e1_stb, input logic [8:0] e1_dc,
                            input logic [8:0] e2_stb, input logic [8:0] e2_dc, input int alu);
      step({tag, "_fetch"}, 1'b0, op, fn, jz, ev(3'd0, RR, NO, AX, ret, 1'b0, 1'b0));
      step({tag, "_exec1"}, 1'b0, op, fn, jz, ev(3'd1, e1_stb, e1_dc, AX, ret, 1'b0, 1'b0));
      step({tag, "_exec2"}, 1'b0, op, fn, jz, ev(3'd2, e2_stb, e2_dc, alu, ret, 1'b0, 1'b0));
   endtask

   task automatic do_reset(input string tag);
      waitrequest = 1'b0;
      rst_n       = 1'b0;
      #1;
      expect_now(tag, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      opcode      = OP_SPECIAL;
      funct       = FN_NONE;
      waitrequest = 1'b0;
      jr_zero     = 1'b0;
      #1;
      do_reset("reset_initial");

      run_instr("addu", OP_SPECIAL, FN_ADDU, 1'b0, 3'd0, IR, SEL, PC|GW|WD|A3, RA, 0);

      step("lw_fetch", 1'b0, OP_LW, FN_NONE, 1'b0, ev(3'd0, RR, NO, AX, 3'd1, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++)
         step("lw_exec1_wait", 1'b1, OP_LW, FN_NONE, 1'b0, ev(3'd1, RR|RA|SB, WD|A3, 0, 3'd1, 1'b0, 1'b0));
      step("lw_exec1_done", 1'b0, OP_LW, FN_NONE, 1'b0, ev(3'd1, IR|RR|RA|SB, WD|A3, 0, 3'd1, 1'b0, 1'b0));
      step("lw_exec2", 1'b0, OP_LW, FN_NONE, 1'b0, ev(3'd2, PC|GW, SB|RA, 0, 3'd1, 1'b0, 1'b0));

      run_instr("ori",  OP_ORI,     FN_NONE, 1'b0, 3'd2, IR, SEL, PC|GW|SB|WD, RA, 3);
      run_instr("subu", OP_SPECIAL, FN_SUBU, 1'b0, 3'd3, IR, SEL, PC|GW|WD|A3, RA, 1);
      run_instr("sw",   OP_SW,      FN_NONE, 1'b0, 3'd4, IR|RW|RA|SB, WD|A3, PC, SB|RA|WD|A3, AX);
      run_instr("lui",  OP_LUI,     FN_NONE, 1'b0, 3'd5, IR, SEL, PC|GW|SB|WD, RA, 5);
      run_instr("xori", OP_XORI,    FN_NONE, 1'b0, 3'd6, IR, SEL, PC|GW|SB|WD, RA, 4);
      run_instr("andi", OP_ANDI,    FN_NONE, 1'b0, 3'd7, IR, SEL, PC|GW|SB|WD, RA, 2);
      // retired_o wrapped from 7 to 0 on the ANDI exit
      run_instr("jr_nonzero", OP_SPECIAL, FN_JR, 1'b0, 3'd0, IR, SEL, PC, SEL, AX);
      run_instr("jr_zero",    OP_SPECIAL, FN_JR, 1'b1, 3'd1, IR, SEL, PC, SEL, AX);
      for (int i = 0; i < 10; i++)
         step("halt_hold", i[0], OP_LW, FN_NONE, 1'b0, ev(3'd3, NO, NO, AX, 3'd2, 1'b0, 1'b0));

      do_reset("reset_after_halt");
      step("ill_fetch", 1'b0, OP_BAD, FN_NONE, 1'b0, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      step("ill_exec1", 1'b0, OP_BAD, FN_NONE, 1'b0, ev(3'd1, NO, SEL, AX, 3'd0, 1'b0, 1'b0));
      for (int i = 0; i < 4; i++)
         step("ill_fault_hold", i[0], OP_SPECIAL, FN_ADDU, 1'b0, ev(3'd4, NO, NO, AX, 3'd0, 1'b1, 1'b0));

      do_reset("reset_after_illegal");
      step("badfn_fetch", 1'b0, OP_SPECIAL, FN_ADD, 1'b0, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      step("badfn_exec1", 1'b0, OP_SPECIAL, FN_ADD, 1'b0, ev(3'd1, NO, SEL, AX, 3'd0, 1'b0, 1'b0));
      step("badfn_fault", 1'b0, OP_SPECIAL, FN_ADD, 1'b0, ev(3'd4, NO, NO, AX, 3'd0, 1'b1, 1'b0));

      do_reset("reset_after_badfn");
      for (int i = 0; i < 3; i++)
         step("to_wait", 1'b1, OP_SPECIAL, FN_ADDU, 1'b0, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      step("to_limit", 1'b1, OP_SPECIAL, FN_ADDU, 1'b0, ev(3'd0, NO, RR, AX, 3'd0, 1'b0, 1'b0));
      for (int i = 0; i < 3; i++)
         step("to_fault_hold", 1'b1, OP_SPECIAL, FN_ADDU, 1'b0, ev(3'd4, NO, NO, AX, 3'd0, 1'b0, 1'b1));

      do_reset("reset_after_timeout");
      run_instr("addu2", OP_SPECIAL, FN_ADDU, 1'b0, 3'd0, IR, SEL, PC|GW|WD|A3, RA, 0);
      step("sw_fetch", 1'b0, OP_SW, FN_NONE, 1'b0, ev(3'd0, RR, NO, AX, 3'd1, 1'b0, 1'b0));
      step("sw_exec1_wait", 1'b1, OP_SW, FN_NONE, 1'b0, ev(3'd1, RW|RA|SB, WD|A3, 0, 3'd1, 1'b0, 1'b0));
      #2;
      expect_now("sw_exec1_hold", ev(3'd1, RW|RA|SB, WD|A3, 0, 3'd1, 1'b0, 1'b0));
      rst_n = 1'b0;
      #1;
      expect_now("sw_async_reset", ev(3'd0, NO, RR, AX, 3'd0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // A stale wait count would push the third wait cycle into a timeout.
      for (int i = 0; i < 3; i++)
         step("post_reset_wait", 1'b1, OP_SW, FN_NONE, 1'b0, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      step("post_reset_fetch_done", 1'b0, OP_SW, FN_NONE, 1'b0, ev(3'd0, RR, NO, AX, 3'd0, 1'b0, 1'b0));
      step("post_reset_sw_exec1", 1'b0, OP_SW, FN_NONE, 1'b0, ev(3'd1, IR|RW|RA|SB, WD|A3, 0, 3'd0, 1'b0, 1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
